// File: rtl/da_idct4_row.sv
`default_nettype none
// ============================================================================
//  Module      : da_idct4_row
//  Description : Bit-serial distributed-arithmetic inverse 4-point DCT term,
//                Y = round(sum COEFk*Ck). It processes one coefficient bit
//                per cycle, starting with the MSB.
//                Optional macro DA_IDCT_SAT_EN: clamp the rounded result to
//                the DW-bit signed range. When the macro is not defined, the
//                result wraps in two's complement.
//  Revision    : 1.0  initial release
// ============================================================================
module da_idct4_row #(
    parameter int DW    = 12,
    parameter int CW    = 12,
    parameter int FRAC  = 10,
    parameter int COEF0 = 512,
    parameter int COEF1 = 669,
    parameter int COEF2 = 512,
    parameter int COEF3 = 277
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] C0,
    input  logic signed [DW-1:0] C1,
    input  logic signed [DW-1:0] C2,
    input  logic signed [DW-1:0] C3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] Y
);

    localparam int LW   = CW + 2;          // LUT entry width
    localparam int AW   = DW + CW + 4;     // accumulator width
    localparam int RW   = AW - FRAC;       // rounded result width
    localparam int CNTW = $clog2(DW);

    localparam logic signed [LW-1:0]   c_coef0  = LW'(COEF0);
    localparam logic signed [LW-1:0]   c_coef1  = LW'(COEF1);
    localparam logic signed [LW-1:0]   c_coef2  = LW'(COEF2);
    localparam logic signed [LW-1:0]   c_coef3  = LW'(COEF3);
    localparam logic signed [AW-1:0]   c_half   = AW'(2 ** (FRAC - 1));
    localparam logic [CNTW-1:0]        c_msb    = CNTW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]        bit_cnt_q, bit_cnt_d;
    logic signed [DW-1:0]   y_q, y_d;

    logic [3:0]             w_addr;
    logic signed [LW-1:0]   w_lut;
    logic signed [AW-1:0]   w_lut_ext;
    logic signed [AW-1:0]   w_acc_step;
    logic signed [AW-1:0]   w_sum;
    logic signed [RW-1:0]   w_rnd;
    logic signed [DW-1:0]   w_y;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Y         = y_q;

    // DA lookup table: sum of the weights whose coefficient bit is set
    always_comb begin
        w_addr = {c0_q[bit_cnt_q], c1_q[bit_cnt_q], c2_q[bit_cnt_q], c3_q[bit_cnt_q]};
        w_lut  = '0;
        if (w_addr[3]) w_lut = w_lut + c_coef0;
        if (w_addr[2]) w_lut = w_lut + c_coef1;
        if (w_addr[1]) w_lut = w_lut + c_coef2;
        if (w_addr[0]) w_lut = w_lut + c_coef3;
        w_lut_ext = {{(AW - LW){w_lut[LW-1]}}, w_lut};
    end

    // Shift-accumulate step; the MSB carries negative (two's-complement sign) weight
    always_comb begin
        if (bit_cnt_q == c_msb) begin
            w_acc_step = -w_lut_ext;
        end else begin
            w_acc_step = (acc_q <<< 1) + w_lut_ext;
        end
    end

    // Round half up on the accumulator value being finalised, then clamp or wrap
    assign w_sum = w_acc_step + c_half;
    assign w_rnd = w_sum[AW-1:FRAC];

`ifdef DA_IDCT_SAT_EN
    localparam logic signed [RW-1:0] c_ymax = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] c_ymin = RW'(-(2 ** (DW - 1)));
    logic w_unused_frac;
    assign w_unused_frac = ^w_sum[FRAC-1:0];

    // Saturate the rounded result to the output range
    always_comb begin
        if (w_rnd > c_ymax) begin
            w_y = c_ymax[DW-1:0];
        end else if (w_rnd < c_ymin) begin
            w_y = c_ymin[DW-1:0];
        end else begin
            w_y = w_rnd[DW-1:0];
        end
    end
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_sum[FRAC-1:0], w_rnd[RW-1:DW]};
    assign w_y           = w_rnd[DW-1:0];
`endif

    // Next-state logic for the FSM and datapath registers
    always_comb begin
        state_d   = state_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        c3_d      = c3_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        y_d       = y_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    c0_d      = C0;
                    c1_d      = C1;
                    c2_d      = C2;
                    c3_d      = C3;
                    bit_cnt_d = c_msb;
                    acc_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = w_acc_step;
                if (bit_cnt_q == '0) begin
                    y_d     = w_y;
                    state_d = S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            c0_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            c3_q      <= '0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            c3_q      <= c3_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            y_q       <= y_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_da_idct4_row.sv
`default_nettype none
// ============================================================================
//  Module      : tb_da_idct4_row
//  Description : Self-checking bench for da_idct4_row. The reference model
//                computes the weighted sum directly and then rounds it.
//                The bench honours DA_IDCT_SAT_EN in the same way as the
//                design does.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_da_idct4_row;

    localparam int DW = 12;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] C0, C1, C2, C3;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] Y;

    int total = 0;
    int bad   = 0;

    da_idct4_row dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .C0       (C0),
        .C1       (C1),
        .C2       (C2),
        .C3       (C3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: plain integer weighted sum, round half up, then clamp or wrap
    function automatic logic signed [DW-1:0] model(input logic signed [DW-1:0] a, b, c, d);
        longint s;
        longint r;
        s = longint'(a) * 512 + longint'(b) * 669 + longint'(c) * 512 + longint'(d) * 277;
        r = (s + 512) >>> 10;
`ifdef DA_IDCT_SAT_EN
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
`endif
        return r[DW-1:0];
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One transaction. On return the bench is in the first out_valid cycle.
    task automatic txn(input logic signed [DW-1:0] a, b, c, d,
                       input logic signed [DW-1:0] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        C0 = a; C1 = b; C2 = c; C3 = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check({tag, "_busy"}, 32'(in_ready), 32'd0);
            step();
            n++;
        end
        check({tag, "_lat"}, n, DW);
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_irdy"}, 32'(in_ready), 32'd0);
        check({tag, "_y"}, Y, exp);
    endtask

    logic signed [DW-1:0] q[$];
    logic signed [DW-1:0] ra, rb, rc, rd, yexp;
    int  last, nacc, cyc;
    bit  acc_now;

    initial begin
        sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        C0 = '0; C1 = '0; C2 = '0; C3 = '0;
        step(); step();
        check("rst_irdy", 32'(in_ready), 32'd1);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_y", Y, 32'd0);
        sys_rst = 1'b0;
        step();

        // Directed values with hand-computed expectations
        txn(12'sd100, 12'sd0, 12'sd0, 12'sd0, 12'sd50, "c0");
        step();
        check("c0_ret_ov", 32'(out_valid), 32'd0);
        check("c0_ret_rdy", 32'(in_ready), 32'd1);
        txn(12'sd0, 12'sd100, 12'sd0, 12'sd0, 12'sd65, "c1");
        step();
        txn(-12'sd100, 12'sd0, 12'sd0, 12'sd0, -12'sd50, "neg");
        step();
`ifdef DA_IDCT_SAT_EN
        txn(12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, "max");
        step();
        txn(-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, "min");
        step();
`else
        txn(12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, -12'sd158, "max");
        step();
        txn(-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 12'sd156, "min");
        step();
`endif

        // Stall in DONE while a new set is offered
        out_ready = 1'b0;
        yexp = model(12'sd30, -12'sd40, 12'sd50, -12'sd60);
        txn(12'sd30, -12'sd40, 12'sd50, -12'sd60, yexp, "stall");
        C0 = 12'sd1000; C1 = 12'sd1000; C2 = -12'sd900; C3 = 12'sd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_ov", 32'(out_valid), 32'd1);
            check("stall_y", Y, yexp);
            check("stall_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("stall_rel_ov", 32'(out_valid), 32'd0);
        check("stall_rel_rdy", 32'(in_ready), 32'd1);

        // Reset asserted in the 6th CALC cycle
        C0 = 12'sd77; C1 = 12'sd88; C2 = 12'sd99; C3 = 12'sd11;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        sys_rst = 1'b1;
        #1;
        check("mrst_ov", 32'(out_valid), 32'd0);
        check("mrst_y", Y, 32'd0);
        check("mrst_rdy", 32'(in_ready), 32'd1);
        step();
        sys_rst = 1'b0;
        step();
        txn(12'sd0, 12'sd0, 12'sd100, 12'sd0, 12'sd50, "post_rst");
        step();

        // Random single transactions
        for (int i = 0; i < 10; i++) begin
            ra = 12'($urandom); rb = 12'($urandom);
            rc = 12'($urandom); rd = 12'($urandom);
            txn(ra, rb, rc, rd, model(ra, rb, rc, rd), "rnd");
            step();
        end

        // Back-to-back stream with in_valid held high
        last = -1; nacc = 0; cyc = 0;
        C0 = 12'($urandom); C1 = 12'($urandom); C2 = 12'($urandom); C3 = 12'($urandom);
        in_valid = 1'b1;
        while (cyc < 300 && !(nacc == 8 && q.size() == 0)) begin
            if (out_valid) begin
                if (q.size() == 0) check("b2b_extra", 32'(out_valid), 32'd0);
                else               check("b2b_y", Y, q.pop_front());
            end
            acc_now = in_ready && in_valid;
            if (acc_now) begin
                if (last >= 0) check("b2b_gap", cyc - last, 14);
                last = cyc;
                q.push_back(model(C0, C1, C2, C3));
                nacc++;
            end
            step();
            cyc++;
            if (acc_now) begin
                if (nacc == 8) in_valid = 1'b0;
                C0 = 12'($urandom); C1 = 12'($urandom);
                C2 = 12'($urandom); C3 = 12'($urandom);
            end
        end
        in_valid = 1'b0;
        check("b2b_count", nacc, 8);
        check("b2b_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
